data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra access wait states (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_enable_read  input  1  load request.
REQ-006 SHALL have port mem_enable_write  input  1  store request.
REQ-007 SHALL have port memory_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port memory_sign_ext  input  1  1 sign-extends byte/half loads, 0 zero-extends.
REQ-009 SHALL have port address  input  32  byte address.
REQ-010 SHALL have port write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port read_data  output  32  extended load result.
REQ-012 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port mem_busy  output  1  request in progress.
REQ-014 SHALL have port misaligned_fault  output  1  one-cycle fault pulse (only with MEM_MISALIGN_TRAP_EN).

Function
REQ-015 SHALL implement states IDLE, WAIT, ACCESS, RESP.
REQ-016 IDLE: on read or write asserted, SHALL latch address, size, sign_ext, write_data and operation; go to WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-017 Read and write asserted together SHALL be accepted as a write.
REQ-018 Requests SHALL only be accepted in IDLE; inputs outside IDLE SHALL be ignored (no queuing).
REQ-019 WAIT: SHALL count WAIT_CYCLES cycles, then go to ACCESS.
REQ-020 ACCESS: write SHALL update only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all); read SHALL capture the selected lanes; then go to RESP.
REQ-021 RESP: mem_ready SHALL be 1 for exactly one cycle; next state IDLE.
REQ-022 Latency: request accepted at edge N SHALL give mem_ready high in cycle N+WAIT_CYCLES+2 counted as cycles after acceptance edge, i.e. WAIT_CYCLES+2 cycles; new request earliest the cycle after RESP.
REQ-023 mem_busy SHALL be 1 in WAIT, ACCESS, RESP; 0 in IDLE.
REQ-024 read_data SHALL update only when a read reaches RESP and SHALL hold otherwise, including across writes.
REQ-025 Word index SHALL be address[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-026 Misaligned: half with addr[0]=1, word/size 11 with addr[1:0]!=00.

Reset
REQ-027 rst SHALL force state IDLE, read_data 0, mem_ready 0, mem_busy 0, misaligned_fault 0, wait counter 0.
REQ-028 rst mid-operation SHALL abort the request; pending write SHALL NOT modify storage; no mem_ready issued.
REQ-029 Storage contents SHALL NOT be cleared by rst.

Configuration
REQ-030 Macro MEM_MISALIGN_TRAP_EN defined: misaligned request SHALL skip storage access, pulse misaligned_fault and mem_ready together in RESP, read_data unchanged.
REQ-031 MEM_MISALIGN_TRAP_EN undefined: misaligned address low bits SHALL be forced to alignment (half: addr[0]=0; word: addr[1:0]=00); misaligned_fault SHALL be tied 0.

Verification
REQ-032 Store word 0xDEADBEEF at 0x10, then load word 0x10 -> read_data 0xDEADBEEF, mem_ready 4 cycles after each acceptance (WAIT_CYCLES=2).
REQ-033 After REQ-032, load byte 0x13 sign_ext=1 -> 0xFFFFFFDE; sign_ext=0 -> 0x000000DE; load half 0x10 sign_ext=1 -> 0xFFFFBEEF.
REQ-034 Store byte 0x55 at 0x11 over 0xDEADBEEF -> word load 0x10 returns 0xDEAD55EF.
REQ-035 Load word 0x12: with MEM_MISALIGN_TRAP_EN -> misaligned_fault=1 with mem_ready, read_data held; without -> returns word at 0x10.
REQ-036 Assert rst during WAIT of store 0x12345678 to 0x20 -> no mem_ready, mem_busy 0 next cycle, later load 0x20 returns prior contents.
REQ-037 Read+write asserted same cycle, then a second request while busy -> write performed, second request ignored, single mem_ready.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory responder: byte/half/word loads and stores with sign/zero extension.
// Latency: request accepted in IDLE -> mem_ready pulse WAIT_CYCLES+2 cycles later; one request in flight.
// Backpressure: none queued; requests seen outside IDLE are dropped. Optional MEM_MISALIGN_TRAP_EN traps misalignment.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enable_read,
  input  logic        mem_enable_write,
  input  logic [1:0]  memory_size,
  input  logic        memory_sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        misaligned_fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt;
  logic          op_write_q;
  logic [1:0]    size_q;      // 00 byte, 01 half, 10 word (11 folded into word)
  logic          sign_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          skip_access;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          in_half, in_word;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word_rd;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    byte_en;
  logic [31:0]   wd_rep;
  logic [31:0]   load_ext;
  logic          do_access;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^address[31:AW+2];
  assign accept  = (state_q == IDLE) && (mem_enable_read || mem_enable_write);
  assign in_half = (memory_size == 2'b01);
  assign in_word = memory_size[1];
  assign idx     = addr_q[AW+1:2];
  assign lane    = addr_q[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  logic in_mis;
  assign in_mis           = (in_half && address[0]) || (in_word && (address[1:0] != 2'b00));
  assign skip_access      = mis_q;
  assign misaligned_fault = (state_q == RESP) && mis_q;

  // Capture the misalignment verdict with the request so RESP can report it.
  always_ff @(posedge clk) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= in_mis;
  end
`else
  assign skip_access      = 1'b0;
  assign misaligned_fault = 1'b0;
`endif

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= ((state_q == WAIT) && (wait_cnt != WAIT_LAST)) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    mem_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        mem_busy = 1'b0;
        if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      end
      WAIT:    if (wait_cnt == WAIT_LAST) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request; without trapping, misaligned low address bits are forced to alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write_q <= 1'b0;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      op_write_q <= mem_enable_write;
      size_q     <= in_word ? 2'b10 : memory_size;
      sign_q     <= memory_sign_ext;
      wdata_q    <= write_data;
`ifdef MEM_MISALIGN_TRAP_EN
      addr_q     <= address[AW+1:0];
`else
      addr_q     <= {address[AW+1:2],
                     in_word ? 2'b00 : (in_half ? {address[1], 1'b0} : address[1:0])};
`endif
    end
  end

  // Lane selection, store replication and load extension.
  always_comb begin
    word_rd = mem[idx];
    byte_v  = word_rd[{lane, 3'b000} +: 8];
    half_v  = lane[1] ? word_rd[31:16] : word_rd[15:0];
    case (size_q)
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wd_rep   = {4{wdata_q[7:0]}};
        load_ext = {{24{sign_q & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep   = {2{wdata_q[15:0]}};
        load_ext = {{16{sign_q & half_v[15]}}, half_v};
      end
      default: begin
        byte_en  = 4'b1111;
        wd_rep   = wdata_q;
        load_ext = word_rd;
      end
    endcase
  end

  assign do_access = (state_q == ACCESS) && !rst && !skip_access;

  // Storage write: only enabled lanes; never cleared by reset.
  always_ff @(posedge clk) begin
    if (do_access && op_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
      end
    end
  end

  // Load result register: changes only when a read completes, holds across writes.
  always_ff @(posedge clk) begin
    if (rst)                            read_data <= 32'h0;
    else if (do_access && !op_write_q)  read_data <= load_ext;
  end
endmodule
